// File: rtl/parking_pkg.sv
// parking_pkg: FSM encoding, status-lamp patterns and width helpers shared by the car-park controller.
package parking_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY_CODE,
        ST_EXIT_CODE,
        ST_GRANT_IN,
        ST_GRANT_OUT,
        ST_DENY,
        ST_LOCKOUT
    } state_e;
    // Lamp vectors are ordered {GREEN, RED, IDLE, LOCK}.
    localparam logic [3:0] LED_IDLE  = 4'b0010;
    localparam logic [3:0] LED_CODE  = 4'b1100;
    localparam logic [3:0] LED_GRANT = 4'b1000;
    localparam logic [3:0] LED_DENY  = 4'b0100;
    localparam logic [3:0] LED_LOCK  = 4'b0101;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
    function automatic logic [3:0] led_of(input state_e s);
        return s == ST_IDLE ? LED_IDLE :
               (s == ST_ENTRY_CODE || s == ST_EXIT_CODE) ? LED_CODE :
               (s == ST_GRANT_IN || s == ST_GRANT_OUT) ? LED_GRANT :
               s == ST_DENY ? LED_DENY : LED_LOCK;
    endfunction
endpackage

// File: rtl/parking_lot_ctrl_btn_edge.sv
// btn_edge: two-flop synchroniser for a raw pushbutton followed by a one-cycle rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic rise_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else sync_q <= {sync_q[1:0], btn_i};
    end
    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: passcode-gated car-park gate controller with per-slot parking timers,
// exit fee display, code-entry timeout and a lockout after repeated wrong codes.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int CODE_LEN     = 4,
    parameter int TICK_DIV     = 100_000_000,
    parameter int TIME_W       = 8,
    parameter int GRANT_TICKS  = 1,
    parameter int CODE_TIMEOUT = 10,
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_TICKS   = 30,
    parameter int SHOW_TICKS   = 3,
    parameter int RATE_SHIFT   = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            sensor_entrance,
    input  logic                            sensor_exit,
    input  logic                            pushbutton_0,
    input  logic                            pushbutton_1,
    input  logic [NUM_SLOTS*CODE_LEN-1:0]   slot_codes,
    output logic [NUM_SLOTS-1:0]            occupied,
    output logic [clog2(NUM_SLOTS+1)-1:0]   num_cars,
    output logic [TIME_W-1:0]               digit_out,
    output logic                            GREEN_LED,
    output logic                            RED_LED,
    output logic                            IDLE_LED,
    output logic                            LOCK_LED
);
    localparam int NC_W  = clog2(NUM_SLOTS + 1);
    localparam int IDX_W = max2(clog2(NUM_SLOTS), 1);
    localparam int KEY_W = clog2(CODE_LEN + 1);
    localparam int TRY_W = clog2(MAX_TRIES + 1);
    localparam int DIV_W = max2(clog2(TICK_DIV), 1);
    localparam int CNT_W = clog2(max2(max2(GRANT_TICKS, CODE_TIMEOUT), max2(LOCK_TICKS, SHOW_TICKS)) + 1);

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] sr_q, sr_d;
    logic [KEY_W-1:0]    kc_q, kc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, show_cnt_q, show_cnt_d, limit;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [TIME_W-1:0]   timer_q [NUM_SLOTS];
    logic [TIME_W-1:0]   timer_d [NUM_SLOTS];
    logic [TIME_W-1:0]   fee_q, fee_d, digit_q, digit_d;
    logic                show_q, show_d;
    logic [3:0]          led_q;
    logic [DIV_W-1:0]    div_q;
    logic                tick, done, rise0, rise1, key_any, key_ok, hit;
    logic [IDX_W-1:0]    hit_idx;

    btn_edge u_btn0 (.clk(clk), .reset_n(reset_n), .btn_i(pushbutton_0), .rise_o(rise0));
    btn_edge u_btn1 (.clk(clk), .reset_n(reset_n), .btn_i(pushbutton_1), .rise_o(rise1));

    // Simultaneous presses still restart the entry timeout but never shift in a bit.
    assign key_any = rise0 | rise1;
    assign key_ok  = rise0 ^ rise1;
    assign tick    = div_q == DIV_W'(TICK_DIV - 1);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_codes[i*CODE_LEN +: CODE_LEN] == sr_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        limit = state_q == ST_LOCKOUT ? CNT_W'(LOCK_TICKS - 1) :
                (state_q == ST_ENTRY_CODE || state_q == ST_EXIT_CODE) ? CNT_W'(CODE_TIMEOUT - 1) :
                CNT_W'(GRANT_TICKS - 1);
        done  = tick && cnt_q == limit;
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        kc_d       = kc_q;
        tries_d    = tries_q;
        occ_d      = occ_q;
        fee_d      = fee_q;
        show_d     = show_q;
        show_cnt_d = show_cnt_q;
        cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
        for (int i = 0; i < NUM_SLOTS; i++)
            timer_d[i] = (tick && occ_q[i] && timer_q[i] != '1) ? timer_q[i] + 1'b1 : timer_q[i];
        if (show_q && tick) begin
            show_d     = show_cnt_q != CNT_W'(SHOW_TICKS - 1);
            show_cnt_d = show_cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                state_d = (sensor_entrance && num_cars < NC_W'(NUM_SLOTS)) ? ST_ENTRY_CODE :
                          (sensor_exit && num_cars != '0) ? ST_EXIT_CODE : ST_IDLE;
                sr_d    = '0;
                kc_d    = '0;
            end
            ST_ENTRY_CODE, ST_EXIT_CODE: begin
                if (kc_q == KEY_W'(CODE_LEN)) begin
                    if (!hit || occ_q[hit_idx] != (state_q == ST_EXIT_CODE)) begin
                        state_d = ST_DENY;
                        tries_d = tries_q + 1'b1;
                    end else if (state_q == ST_ENTRY_CODE) begin
                        state_d          = ST_GRANT_IN;
                        tries_d          = '0;
                        occ_d[hit_idx]   = 1'b1;
                        timer_d[hit_idx] = '0;
                    end else begin
                        state_d        = ST_GRANT_OUT;
                        tries_d        = '0;
                        occ_d[hit_idx] = 1'b0;
                        fee_d          = timer_q[hit_idx] >> RATE_SHIFT;
                        show_d         = 1'b1;
                        show_cnt_d     = '0;
                    end
                end else if (key_any) begin
                    cnt_d = '0;
                    if (key_ok) begin
                        sr_d = (sr_q << 1) | CODE_LEN'(rise1);
                        kc_d = kc_q + 1'b1;
                    end
                end else if (done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_IN, ST_GRANT_OUT: state_d = done ? ST_IDLE : state_q;
            ST_DENY: state_d = !done ? ST_DENY : tries_q == TRY_W'(MAX_TRIES) ? ST_LOCKOUT : ST_IDLE;
            ST_LOCKOUT: begin
                state_d = done ? ST_IDLE : ST_LOCKOUT;
                tries_d = done ? '0 : tries_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        digit_d = show_d ? fee_d : TIME_W'($countones(occ_d));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            kc_q       <= '0;
            cnt_q      <= '0;
            tries_q    <= '0;
            occ_q      <= '0;
            fee_q      <= '0;
            show_q     <= 1'b0;
            show_cnt_q <= '0;
            digit_q    <= '0;
            led_q      <= LED_IDLE;
            div_q      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) timer_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            kc_q       <= kc_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            occ_q      <= occ_d;
            fee_q      <= fee_d;
            show_q     <= show_d;
            show_cnt_q <= show_cnt_d;
            digit_q    <= digit_d;
            led_q      <= led_of(state_q);
            div_q      <= tick ? '0 : div_q + 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) timer_q[i] <= timer_d[i];
        end
    end

    assign occupied  = occ_q;
    assign num_cars  = NC_W'($countones(occ_q));
    assign digit_out = digit_q;
    assign {GREEN_LED, RED_LED, IDLE_LED, LOCK_LED} = led_q;
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb_parking_lot_ctrl: directed plus randomised transactions against a transaction-level car-park model.
module tb_parking_lot_ctrl;
    localparam int N  = 4;
    localparam int CL = 4;
    localparam int TD = 10;
    localparam int TW = 8;

    logic clk = 1'b0, reset_n = 1'b0, sen = 1'b0, sex = 1'b0, pb0 = 1'b0, pb1 = 1'b0;
    logic [N*CL-1:0] codes = {4'b0011, 4'b1010, 4'b0101, 4'b1100};
    logic [N-1:0]    occupied;
    logic [2:0]      num_cars;
    logic [TW-1:0]   digit_out;
    logic            g_led, r_led, i_led, l_led;

    parking_lot_ctrl #(.NUM_SLOTS(N), .CODE_LEN(CL), .TICK_DIV(TD), .TIME_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .sensor_entrance(sen), .sensor_exit(sex),
        .pushbutton_0(pb0), .pushbutton_1(pb1), .slot_codes(codes),
        .occupied(occupied), .num_cars(num_cars), .digit_out(digit_out),
        .GREEN_LED(g_led), .RED_LED(r_led), .IDLE_LED(i_led), .LOCK_LED(l_led)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; one-second ticks land on every TD-th edge.
    int ecount;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ecount <= 0;
        else ecount <= ecount + 1;
    end

    int nvec = 0, nerr = 0, last_m, m_tries;
    bit m_occ [N];
    int m_in [N];
    logic [CL-1:0] m_code [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic leds(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, g_led, r_led, i_led, l_led}, {28'd0, exp});
    endtask

    task automatic wait_ec(input int n);
        while (ecount < n) @(negedge clk);
    endtask

    task automatic press(input bit b0, input bit b1);
        @(negedge clk);
        pb0 = b0;
        pb1 = b1;
        last_m = ecount;
        repeat (2) @(negedge clk);
        pb0 = 1'b0;
        pb1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int cars();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_occ[i];
        return c;
    endfunction

    // Fee = whole ticks parked (saturated to the timer range) divided by 4.
    function automatic int fee_of(input int g_in, input int g_out);
        int n = (g_out - 1) / TD - g_in / TD;
        if (n > (1 << TW) - 1) n = (1 << TW) - 1;
        return n >> 2;
    endfunction

    task automatic key_code(input logic [CL-1:0] code);
        for (int k = CL - 1; k >= 0; k--) begin
            press(!code[k], code[k]);
            if (k == CL - 1) leds("code_leds", 4'b1100);
        end
    endtask

    task automatic do_txn(input bit entry, input logic [CL-1:0] code, input bit both_first);
        int idx, g, t1, t3, fee;
        bit ok;
        @(negedge clk);
        if (entry) sen = 1'b1;
        else sex = 1'b1;
        @(negedge clk);
        sen = 1'b0;
        sex = 1'b0;
        if (both_first) press(1'b1, 1'b1);
        key_code(code);
        g = last_m + 4;
        wait_ec(g + 1);
        idx = -1;
        for (int i = N - 1; i >= 0; i--) if (m_code[i] == code) idx = i;
        ok = idx >= 0 && (m_occ[idx] != entry);
        fee = 0;
        if (ok) begin
            if (entry) begin
                m_occ[idx] = 1'b1;
                m_in[idx] = g;
            end else begin
                fee = fee_of(m_in[idx], g);
                m_occ[idx] = 1'b0;
            end
            m_tries = 0;
            leds("grant_leds", 4'b1000);
        end else begin
            m_tries++;
            leds("deny_leds", 4'b0100);
        end
        for (int i = 0; i < N; i++) chk("occupied", occupied[i], m_occ[i]);
        chk("num_cars", num_cars, cars());
        chk("digit", digit_out, (ok && !entry) ? fee : cars());
        if (ok && !entry) begin
            t3 = (g / TD + 3) * TD;
            wait_ec(t3 - 1);
            chk("fee_hold", digit_out, fee);
            wait_ec(t3);
            chk("fee_end", digit_out, cars());
        end else if (!ok && m_tries == 3) begin
            m_tries = 0;
            t1 = (g / TD + 1) * TD;
            wait_ec(t1 + 1);
            leds("lock_leds", 4'b0101);
            sen = 1'b1;
            press(1'b0, 1'b1);
            sen = 1'b0;
            wait_ec(t1 + 30 * TD);
            leds("lock_last", 4'b0101);
            chk("lock_num_cars", num_cars, cars());
            wait_ec(t1 + 30 * TD + 1);
            leds("lock_done", 4'b0010);
        end else begin
            wait_ec(g + 12);
            leds("back_idle", 4'b0010);
        end
    endtask

    task automatic chk_reset();
        chk("rst_occupied", occupied, 0);
        chk("rst_num_cars", num_cars, 0);
        chk("rst_digit", digit_out, 0);
        leds("rst_leds", 4'b0010);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, en;
        bit entry;
        logic [CL-1:0] code;
        for (int i = 0; i < N; i++) begin
            m_code[i] = codes[i*CL +: CL];
            m_occ[i] = 1'b0;
            m_in[i] = 0;
        end
        m_tries = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // Enter on slot 0, park, then leave and watch the fee window.
        do_txn(1'b1, 4'b1100, 1'b0);
        repeat (250) @(negedge clk);
        do_txn(1'b0, 4'b1100, 1'b0);
        // Three wrong codes in a row end in lockout.
        repeat (3) do_txn(1'b1, 4'b1111, 1'b0);
        // Simultaneous presses enter nothing; silence then aborts entry.
        @(negedge clk);
        sen = 1'b1;
        s = ecount + 1;
        @(negedge clk);
        sen = 1'b0;
        press(1'b1, 1'b1);
        wait_ec(s + 90);
        leds("before_timeout", 4'b1100);
        wait_ec(s + 130);
        leds("after_timeout", 4'b0010);
        do_txn(1'b1, m_code[1], 1'b1);
        // Fill the lot, try to enter while full, then reuse a parked code.
        do_txn(1'b1, m_code[0], 1'b0);
        do_txn(1'b1, m_code[2], 1'b0);
        do_txn(1'b1, m_code[3], 1'b0);
        @(negedge clk);
        sen = 1'b1;
        repeat (20) @(negedge clk);
        leds("full_stays_idle", 4'b0010);
        chk("full_occupied", occupied, 4'b1111);
        sen = 1'b0;
        do_txn(1'b0, m_code[3], 1'b0);
        do_txn(1'b1, m_code[0], 1'b0);
        for (int t = 0; t < 16; t++) begin
            en = cars();
            entry = (en == 0) ? 1'b1 : (en == N) ? 1'b0 : 1'($urandom_range(0, 1));
            code = $urandom_range(0, 1) ? m_code[$urandom_range(0, N - 1)] : CL'($urandom_range(0, 15));
            do_txn(entry, code, 1'b0);
        end
        for (int i = 0; i < N; i++) if (m_occ[i]) do_txn(1'b0, m_code[i], 1'b0);
        // Long stay drives the parking timer into saturation.
        do_txn(1'b1, m_code[2], 1'b0);
        repeat (2600) @(negedge clk);
        do_txn(1'b0, m_code[2], 1'b0);
        // Reset asserted while the gate is granting entry.
        @(negedge clk);
        sen = 1'b1;
        @(negedge clk);
        sen = 1'b0;
        key_code(m_code[1]);
        wait_ec(last_m + 5);
        leds("pre_reset_grant", 4'b1000);
        #2 reset_n = 1'b0;
        #1 chk_reset();
        for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
        m_tries = 0;
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(1'b1, m_code[1], 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
